// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC multiplexed-bus master.
package rtc_bus_pkg;

   // Transaction-level sequencing states of the bus master
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_NEXT,
      ST_DONE
   } state_e;

   // Sub-phases of one bus cycle, in the order they occur
   typedef enum logic [1:0] {
      PH_SETUP,
      PH_PULSE,
      PH_HOLD,
      PH_REC
   } phase_e;

   localparam int DEF_T_SETUP = 2;
   localparam int DEF_T_PULSE = 10;
   localparam int DEF_T_HOLD  = 2;
   localparam int DEF_T_REC   = 4;

   // Wide enough for any practical phase length at 100 MHz
   localparam int TCNT_W = 16;

   localparam logic [7:0] CMD_TRANSFER = 8'hF0;

endpackage

// File: rtl/rtc_phase_timer.sv
// Single down-counter that walks one bus cycle through SETUP, PULSE, HOLD, REC.
// A start pulse (re)loads SETUP; cycle_done flags the last REC clock so the
// master can chain the next bus cycle with no gap.
module rtc_phase_timer
   import rtc_bus_pkg::*;
#(
   parameter int T_SETUP = DEF_T_SETUP,
   parameter int T_PULSE = DEF_T_PULSE,
   parameter int T_HOLD  = DEF_T_HOLD,
   parameter int T_REC   = DEF_T_REC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [1:0] phase,
   output logic       pulse_last,
   output logic       cycle_done
);

   phase_e              phase_q, phase_d;
   logic [TCNT_W-1:0]   cnt_q, cnt_d;
   logic                active_q, active_d;

   function automatic logic [TCNT_W-1:0] load_val(input phase_e p);
      case (p)
         PH_SETUP: return TCNT_W'(T_SETUP - 1);
         PH_PULSE: return TCNT_W'(T_PULSE - 1);
         PH_HOLD:  return TCNT_W'(T_HOLD - 1);
         default:  return TCNT_W'(T_REC - 1);
      endcase
   endfunction

   // Next-count: start wins, otherwise count down and step to the next phase at zero
   always_comb begin
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (start) begin
         phase_d  = PH_SETUP;
         cnt_d    = load_val(PH_SETUP);
         active_d = 1'b1;
      end else if (active_q) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - TCNT_W'(1);
         end else if (phase_q == PH_REC) begin
            active_d = 1'b0;
         end else begin
            phase_d = phase_e'(phase_q + 2'd1);
            cnt_d   = load_val(phase_d);
         end
      end
   end

   // Timer state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q  <= PH_SETUP;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   assign phase      = phase_q;
   assign pulse_last = active_q && (phase_q == PH_PULSE) && (cnt_q == '0);
   assign cycle_done = active_q && (phase_q == PH_REC) && (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// Sequenced master for the RTC multiplexed address/data bus: optional command
// cycle, then address/data cycle pairs with address auto-increment.
module rtc_bus_master
   import rtc_bus_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int LEN_W   = 4,
   parameter int T_SETUP = DEF_T_SETUP,
   parameter int T_PULSE = DEF_T_PULSE,
   parameter int T_HOLD  = DEF_T_HOLD,
   parameter int T_REC   = DEF_T_REC,
   parameter logic [DATA_W-1:0] CMD = DATA_W'(CMD_TRANSFER)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              rw,
   input  logic              cmd_pre,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] wdata,
   output logic              wdata_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              busy,
   output logic              done,
   output logic              cs_n,
   output logic              ad,
   output logic              rd_n,
   output logic              wr_n,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   input  logic [DATA_W-1:0] bus_in
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic              rw_q, rw_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rdata_valid_q, rdata_valid_d;
   logic              wdata_ack_q, wdata_ack_d;

   logic              tmr_start;
   logic [1:0]        tmr_phase_raw;
   phase_e            tmr_phase;
   logic              pulse_last;
   logic              cycle_done;
   logic              in_bus_cycle;
   logic              drive_en;

   rtc_phase_timer #(
      .T_SETUP (T_SETUP),
      .T_PULSE (T_PULSE),
      .T_HOLD  (T_HOLD),
      .T_REC   (T_REC)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .start      (tmr_start),
      .phase      (tmr_phase_raw),
      .pulse_last (pulse_last),
      .cycle_done (cycle_done)
   );

   assign tmr_phase = phase_e'(tmr_phase_raw);

   // Next-state logic: chains bus cycles and restarts the timer on each new phase
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      remain_d      = remain_q;
      rw_d          = rw_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      wdata_ack_d   = 1'b0;
      tmr_start     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               rw_d      = rw;
               addr_d    = addr;
               remain_d  = (len == '0) ? LEN_W'(1) : len;
               if (!rw) wdata_d = wdata;
               state_d   = (cmd_pre && rw) ? ST_CMD : ST_ADDR;
               tmr_start = 1'b1;
            end
         end
         ST_CMD: begin
            if (cycle_done) begin
               state_d   = ST_ADDR;
               tmr_start = 1'b1;
            end
         end
         ST_ADDR: begin
            if (cycle_done) begin
               tmr_start = 1'b1;
               if (rw_q) begin
                  state_d = ST_RDATA;
               end else begin
                  // Byte for this data cycle is captured as the cycle begins
                  state_d     = ST_WDATA;
                  wdata_d     = wdata;
                  wdata_ack_d = 1'b1;
               end
            end
         end
         ST_WDATA, ST_RDATA: begin
            if ((state_q == ST_RDATA) && pulse_last) begin
               rdata_d       = bus_in;
               rdata_valid_d = 1'b1;
            end
            if (cycle_done) state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (remain_q > LEN_W'(1)) begin
               remain_d  = remain_q - LEN_W'(1);
               addr_d    = addr_q + ADDR_W'(1);
               state_d   = ST_ADDR;
               tmr_start = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Master state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         remain_q      <= '0;
         rw_q          <= 1'b0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         wdata_ack_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remain_q      <= remain_d;
         rw_q          <= rw_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         wdata_ack_q   <= wdata_ack_d;
      end
   end

   assign in_bus_cycle = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                         (state_q == ST_WDATA) || (state_q == ST_RDATA);
   assign drive_en     = in_bus_cycle && (state_q != ST_RDATA) && (tmr_phase != PH_REC);

   // Pin decode from state and phase; only one strobe can ever be low
   always_comb begin
      cs_n    = 1'b1;
      ad      = 1'b1;
      rd_n    = 1'b1;
      wr_n    = 1'b1;
      bus_out = '0;
      if (in_bus_cycle) begin
         ad = (state_q == ST_WDATA) || (state_q == ST_RDATA);
         if (tmr_phase != PH_REC) cs_n = 1'b0;
         if (tmr_phase == PH_PULSE) begin
            if (state_q == ST_RDATA) rd_n = 1'b0;
            else                     wr_n = 1'b0;
         end
      end
      if (drive_en) begin
         case (state_q)
            ST_CMD:  bus_out = CMD;
            ST_ADDR: bus_out = DATA_W'(addr_q);
            default: bus_out = wdata_q;
         endcase
      end
   end

   assign bus_oe      = drive_en;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign wdata_ack   = wdata_ack_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Bench for rtc_bus_master: cycle-level expected pin model built from the
// transaction description, plus literal checks on latency and captured bytes.
`timescale 1ns/1ps
module tb_rtc_bus_master;
   import rtc_bus_pkg::*;

   localparam int TS = 2, TP = 10, TH = 2, TR = 4;
   localparam int T  = TS + TP + TH + TR;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, req, req2, rw, cmd_pre;
   logic [7:0] addr, wdata;
   logic [3:0] len;
   logic       wdata_ack, rdata_valid, busy, done, cs_n, ad, rd_n, wr_n, bus_oe;
   logic [7:0] rdata, bus_out, bus_in;
   logic       wdata_ack2, rdata_valid2, busy2, done2, cs_n2, ad2, rd_n2, wr_n2, bus_oe2;
   logic [7:0] rdata2, bus_out2;
   logic [7:0] bus_in2 = 8'h00;
   logic [7:0] last_addr = 8'h00;

   rtc_bus_master dut (
      .clk(clk), .reset(reset), .req(req), .rw(rw), .cmd_pre(cmd_pre), .addr(addr),
      .len(len), .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata),
      .rdata_valid(rdata_valid), .busy(busy), .done(done), .cs_n(cs_n), .ad(ad),
      .rd_n(rd_n), .wr_n(wr_n), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
   );

   rtc_bus_master #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_REC(1)) dut2 (
      .clk(clk), .reset(reset), .req(req2), .rw(rw), .cmd_pre(cmd_pre), .addr(addr),
      .len(len), .wdata(wdata), .wdata_ack(wdata_ack2), .rdata(rdata2),
      .rdata_valid(rdata_valid2), .busy(busy2), .done(done2), .cs_n(cs_n2), .ad(ad2),
      .rd_n(rd_n2), .wr_n(wr_n2), .bus_out(bus_out2), .bus_oe(bus_oe2), .bus_in(bus_in2)
   );

   // RTC register model: reads return address XOR 0x7D
   always @(posedge clk) if (!cs_n && !ad && !wr_n) last_addr <= bus_out;
   assign bus_in = rd_n ? 8'h00 : (last_addr ^ 8'h7D);

   typedef struct packed {
      logic       cs_n, ad, rd_n, wr_n, oe;
      logic [7:0] bout;
      logic       busy, done, wack, rv;
      logic [7:0] rd;
   } exp_t;

   exp_t       expq[$];
   int         vecs = 0, errs = 0;
   logic       chk_en = 1'b0;
   logic [7:0] wbytes [0:3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vecs++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // kind: 0 = command/address, 1 = write data, 2 = read data
   task automatic push_phase(input int kind, input logic [7:0] val);
      for (int o = 0; o < T; o++) begin
         exp_t e;
         logic low;
         low    = (o >= TS) && (o < TS + TP);
         e.cs_n = (o >= TS + TP + TH);
         e.ad   = (kind != 0);
         e.rd_n = !(low && kind == 2);
         e.wr_n = !(low && kind != 2);
         e.oe   = (kind != 2) && !e.cs_n;
         e.bout = val;
         e.busy = 1'b1;
         e.done = 1'b0;
         e.wack = (kind == 1) && (o == 0);
         e.rv   = (kind == 2) && (o == TS + TP);
         e.rd   = val;
         expq.push_back(e);
      end
   endtask

   task automatic push_gap(input logic d);
      exp_t e;
      e = '0;
      e.cs_n = 1'b1; e.ad = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
      e.busy = 1'b1; e.done = d;
      expq.push_back(e);
   endtask

   task automatic build(input logic r, input logic cp, input logic [7:0] a, input int n,
                        input logic [7:0] wb [0:3]);
      if (r && cp) push_phase(0, 8'hF0);
      for (int k = 0; k < n; k++) begin
         logic [7:0] ak;
         ak = a + 8'(k);
         push_phase(0, ak);
         if (r) push_phase(2, ak ^ 8'h7D);
         else   push_phase(1, wb[k]);
         push_gap(1'b0);
      end
      push_gap(1'b1);
   endtask

   // Cycle compare against the model; idle expectation when nothing is queued
   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         logic bad;
         if (expq.size() > 0) begin
            e = expq.pop_front();
         end else begin
            e = '0;
            e.cs_n = 1'b1; e.ad = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
         end
         bad = (cs_n !== e.cs_n) || (rd_n !== e.rd_n) || (wr_n !== e.wr_n) ||
               (bus_oe !== e.oe) || (busy !== e.busy) || (done !== e.done) ||
               (wdata_ack !== e.wack) || (rdata_valid !== e.rv) ||
               (!e.cs_n && (ad !== e.ad)) || (e.oe && (bus_out !== e.bout)) ||
               (e.rv && (rdata !== e.rd));
         vecs++;
         if (bad) begin
            errs++;
            $display("FAIL cycle @%0t: got cs_n=%b ad=%b rd_n=%b wr_n=%b oe=%b bus=%02h busy=%b done=%b ack=%b rv=%b rd=%02h, expected cs_n=%b ad=%b rd_n=%b wr_n=%b oe=%b bus=%02h busy=%b done=%b ack=%b rv=%b rd=%02h",
                     $time, cs_n, ad, rd_n, wr_n, bus_oe, bus_out, busy, done, wdata_ack,
                     rdata_valid, rdata, e.cs_n, e.ad, e.rd_n, e.wr_n, e.oe, e.bout,
                     e.busy, e.done, e.wack, e.rv, e.rd);
         end
      end
   end

   // Bus monitor: first beat of each wr_n pulse, pulse lengths, read bytes, acks
   logic [8:0] capq[$];
   int         lowlen[$];
   logic [7:0] rdq[$];
   int         lowcnt = 0, ackcnt = 0;
   always @(negedge clk) begin
      if (!wr_n) begin
         if (lowcnt == 0) capq.push_back({ad, bus_out});
         lowcnt++;
      end else if (lowcnt != 0) begin
         lowlen.push_back(lowcnt);
         lowcnt = 0;
      end
      if (rdata_valid) rdq.push_back(rdata);
      if (wdata_ack) ackcnt++;
   end

   task automatic run_txn(input string name, input logic r, input logic cp,
                          input logic [7:0] a, input logic [3:0] l, input int exp_lat);
      int n, cyc, bi;
      n = (l == 0) ? 1 : int'(l);
      capq.delete(); lowlen.delete(); rdq.delete(); ackcnt = 0;
      @(negedge clk);
      rw = r; cmd_pre = cp; addr = a; len = l; wdata = wbytes[0]; bi = 0; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      build(r, cp, a, n, wbytes);
      for (cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         if (wdata_ack) begin
            bi++;
            if (bi < 4) wdata = wbytes[bi];
         end
         if (done) break;
      end
      check({name, " latency"}, cyc, exp_lat);
      @(negedge clk);
      check({name, " model drained"}, expq.size(), 0);
      $display("txn %s: rw=%0d cmd_pre=%0d addr=%02h len=%0d done after %0d cycles",
               name, r, cp, a, l, cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, wl2, ack2, busy_after;
      logic seen;
      logic [8:0] c2[$];
      reset = 1'b0; req = 1'b0; req2 = 1'b0; rw = 1'b0; cmd_pre = 1'b0;
      addr = 8'h00; len = 4'd0; wdata = 8'h00;
      for (int i = 0; i < 4; i++) wbytes[i] = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst cs_n", cs_n, 1); check("rst ad", ad, 1);
      check("rst rd_n", rd_n, 1); check("rst wr_n", wr_n, 1);
      check("rst bus_oe", bus_oe, 0); check("rst bus_out", bus_out, 0);
      check("rst busy", busy, 0); check("rst done", done, 0);
      check("rst rdata", rdata, 0); check("rst rdata_valid", rdata_valid, 0);
      check("rst wdata_ack", wdata_ack, 0);
      $display("txn reset: idle outputs checked");
      @(negedge clk);
      reset = 1'b1;
      chk_en = 1'b1;

      // Single write
      wbytes[0] = 8'h45;
      run_txn("single_write", 1'b0, 1'b0, 8'h21, 4'd0, 38);
      check("sw beats", capq.size(), 2);
      if (capq.size() == 2) begin
         check("sw addr beat", capq[0], {1'b0, 8'h21});
         check("sw data beat", capq[1], {1'b1, 8'h45});
      end
      if (lowlen.size() > 0) check("sw wr_n width", lowlen[0], 10);
      check("sw acks", ackcnt, 1);

      // Single read with command
      run_txn("single_read_cmd", 1'b1, 1'b1, 8'h24, 4'd0, 56);
      check("sr beats", capq.size(), 2);
      if (capq.size() == 2) begin
         check("sr cmd beat", capq[0], {1'b0, 8'hF0});
         check("sr addr beat", capq[1], {1'b0, 8'h24});
      end
      check("sr valid count", rdq.size(), 1);
      check("sr rdata", rdata, 8'h59);

      // Burst read with address wrap
      run_txn("burst_read", 1'b1, 1'b0, 8'hFE, 4'd3, 112);
      check("br beats", capq.size(), 3);
      if (capq.size() == 3) begin
         check("br addr0", capq[0], {1'b0, 8'hFE});
         check("br addr1", capq[1], {1'b0, 8'hFF});
         check("br addr2", capq[2], {1'b0, 8'h00});
      end
      check("br valid count", rdq.size(), 3);
      if (rdq.size() == 3) begin
         check("br data0", rdq[0], 8'h83);
         check("br data1", rdq[1], 8'h82);
         check("br data2", rdq[2], 8'h7D);
      end

      // Burst write
      wbytes[0] = 8'h10; wbytes[1] = 8'h11;
      run_txn("burst_write", 1'b0, 1'b0, 8'h30, 4'd2, 75);
      check("bw beats", capq.size(), 4);
      if (capq.size() == 4) begin
         check("bw a0", capq[0], {1'b0, 8'h30});
         check("bw d0", capq[1], {1'b1, 8'h10});
         check("bw a1", capq[2], {1'b0, 8'h31});
         check("bw d1", capq[3], {1'b1, 8'h11});
      end
      check("bw acks", ackcnt, 2);

      // Reset during a wr_n-low pulse
      @(negedge clk);
      rw = 1'b0; cmd_pre = 1'b0; addr = 8'h50; len = 4'd0; wdata = 8'hA5; req = 1'b1;
      wbytes[0] = 8'hA5;
      @(posedge clk); #1;
      req = 1'b0;
      build(1'b0, 1'b0, 8'h50, 1, wbytes);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (!wr_n) seen = 1'b1;
      end
      check("rst mid-pulse reached", seen, 1);
      chk_en = 1'b0;
      expq.delete();
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort wr_n", wr_n, 1); check("abort cs_n", cs_n, 1);
      check("abort bus_oe", bus_oe, 0); check("abort busy", busy, 0);
      $display("txn reset_mid_pulse: abort outputs checked");
      @(negedge clk);
      reset = 1'b1;
      chk_en = 1'b1;
      wbytes[0] = 8'h66;
      run_txn("write_after_reset", 1'b0, 1'b0, 8'h22, 4'd0, 38);

      // Minimal timing instance; req while busy must be ignored
      @(negedge clk);
      rw = 1'b0; cmd_pre = 1'b0; addr = 8'h40; len = 4'd0; wdata = 8'h5A; req2 = 1'b1;
      @(posedge clk); #1;
      req2 = 1'b0;
      wl2 = 0; ack2 = 0;
      for (cyc = 1; cyc <= 100; cyc++) begin
         @(negedge clk);
         if (cyc == 2) req2 = 1'b1;
         if (cyc == 4) req2 = 1'b0;
         if (!wr_n2) begin
            wl2++;
            c2.push_back({ad2, bus_out2});
         end
         if (wdata_ack2) ack2++;
         if (done2) break;
      end
      req2 = 1'b0;
      check("fast latency", cyc, 10);
      check("fast wr_n low cycles", wl2, 2);
      check("fast acks", ack2, 1);
      if (c2.size() == 2) begin
         check("fast addr beat", c2[0], {1'b0, 8'h40});
         check("fast data beat", c2[1], {1'b1, 8'h5A});
      end
      busy_after = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy2) busy_after++;
      end
      check("fast no queued req", busy_after, 0);
      $display("txn fast_write: done after %0d cycles", cyc);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
